// File: rtl/vga_fetch_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_fetch_ctrl_if : memory read bus and VGA FIFO write port       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface vga_fetch_ctrl_if;
  logic        mem_req;
  logic [25:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [23:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_full;

  modport master (
    output mem_req, mem_addr, fifo_data, fifo_valid,
    input  mem_ack, mem_rvalid, mem_rdata, fifo_full
  );

  modport slave (
    input  mem_req, mem_addr, fifo_data, fifo_valid,
    output mem_ack, mem_rvalid, mem_rdata, fifo_full
  );
endinterface
`default_nettype wire

// File: rtl/vga_fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_fetch_ctrl : streams one frame of 32-bit reads into VGA FIFO  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module vga_fetch_ctrl #(
  parameter int H_PIXELS        = 640,
  parameter int V_LINES         = 480,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [25:0]      fb_base,
  input  logic             frame_start,
  vga_fetch_ctrl_if.master bus,
  output logic             busy,
  output logic             overrun
);

  localparam int XW = $clog2(H_PIXELS + 1);
  localparam int YW = $clog2(V_LINES + 1);
  localparam logic [XW-1:0] c_x_last  = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] c_y_last  = YW'(V_LINES - 1);
  localparam logic [3:0]    c_max_out = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_mem_req;
  logic [25:0] r_addr;
  logic        r_fifo_valid;
  logic [23:0] r_fifo_data;
  logic        r_busy;
  logic        r_overrun;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [3:0]  r_outstanding;

  logic       w_accept;
  logic       w_rsp;
  logic       w_x_last;
  logic       w_last;
  logic       w_room;
  logic [3:0] w_out_next;
  logic       w_unused;

  assign w_accept   = r_mem_req && bus.mem_ack;
  // A response with nothing outstanding is stray (e.g. issued before a reset).
  assign w_rsp      = bus.mem_rvalid && (r_outstanding != 4'd0);
  assign w_out_next = r_outstanding + {3'd0, w_accept} - {3'd0, w_rsp};
  assign w_room     = !bus.fifo_full && (w_out_next < c_max_out);
  assign w_x_last   = (r_x == c_x_last);
  assign w_last     = w_x_last && (r_y == c_y_last);
  assign w_unused   = &{1'b0, bus.mem_rdata[31:24], fb_base[1:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_mem_req     <= 1'b0;
      r_addr        <= 26'd0;
      r_fifo_valid  <= 1'b0;
      r_fifo_data   <= 24'd0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_outstanding <= 4'd0;
    end else begin
      r_outstanding <= w_out_next;
      r_fifo_valid  <= w_rsp;
      if (w_rsp) begin
        r_fifo_data <= bus.mem_rdata[23:0];
      end

      if (w_accept) begin
        r_addr <= r_addr + 26'd4;
        if (w_x_last) begin
          r_x <= '0;
          r_y <= r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end

      case (r_state)
        IDLE: begin
          if (frame_start && enable) begin
            r_state   <= FETCH;
            r_busy    <= 1'b1;
            r_addr    <= {fb_base[25:2], 2'b00};
            r_x       <= '0;
            r_y       <= '0;
            r_mem_req <= w_room;
          end
        end
        FETCH: begin
          if (frame_start) begin
            r_overrun <= 1'b1;
            r_state   <= DRAIN;
            r_mem_req <= 1'b0;
          end else if (w_accept && w_last) begin
            r_state   <= DRAIN;
            r_mem_req <= 1'b0;
          end else if (r_mem_req && !bus.mem_ack) begin
            // An offered request stays up until taken, even across enable/full.
            r_mem_req <= 1'b1;
          end else if (!enable) begin
            r_state   <= DRAIN;
            r_mem_req <= 1'b0;
          end else begin
            r_mem_req <= w_room;
          end
        end
        DRAIN: begin
          if (frame_start) begin
            r_overrun <= 1'b1;
          end
          if (w_out_next == 4'd0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req    = r_mem_req;
  assign bus.mem_addr   = r_addr;
  assign bus.fifo_valid = r_fifo_valid;
  assign bus.fifo_data  = r_fifo_data;
  assign busy           = r_busy;
  assign overrun        = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_vga_fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vga_fetch_ctrl : directed bench, 4x2 frame plus 8x4 limit DUT  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_vga_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [25:0] fb_base;
  logic        frame_start;
  logic        frame_start2;
  logic        busy, overrun, busy2, overrun2;

  logic        auto_rsp;
  logic        man_rv;
  logic [31:0] man_rd;

  int errors = 0;
  int checks = 0;

  logic [25:0] got_addr[$];
  logic [23:0] got_pix[$];
  int          lim_acc = 0;

  logic        st0_v = 1'b0, st1_v = 1'b0;
  logic [25:0] st0_a = 26'd0, st1_a = 26'd0;

  vga_fetch_ctrl_if bus ();
  vga_fetch_ctrl_if bus2 ();

  vga_fetch_ctrl #(.H_PIXELS(4), .V_LINES(2), .MAX_OUTSTANDING(8)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .fb_base(fb_base),
    .frame_start(frame_start), .bus(bus), .busy(busy), .overrun(overrun)
  );

  vga_fetch_ctrl #(.H_PIXELS(8), .V_LINES(4), .MAX_OUTSTANDING(8)) u_lim (
    .clk(clk), .reset(reset), .enable(enable), .fb_base(fb_base),
    .frame_start(frame_start2), .bus(bus2), .busy(busy2), .overrun(overrun2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [25:0] a);
    return {8'hA5, a[23:0] ^ 24'h3C3C3C};
  endfunction

  // Memory model: accepted at edge E, rvalid sampled by the DUT at edge E+2.
  always @(posedge clk) begin
    st0_v = bus.mem_req && bus.mem_ack && reset;
    st0_a = bus.mem_addr;
    if (st0_v) got_addr.push_back(bus.mem_addr);
    if (bus2.mem_req && bus2.mem_ack && reset) lim_acc++;
  end

  always @(negedge clk) begin
    bus.mem_rvalid = auto_rsp ? st1_v : man_rv;
    bus.mem_rdata  = auto_rsp ? mem_word(st1_a) : man_rd;
    st1_v = st0_v;
    st1_a = st0_a;
    if (bus.fifo_valid) got_pix.push_back(bus.fifo_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 80) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    int ba, bp;
    reset = 1'b0; enable = 1'b0; fb_base = 26'd0; frame_start = 1'b0; frame_start2 = 1'b0;
    auto_rsp = 1'b1; man_rv = 1'b0; man_rd = 32'd0;
    bus.mem_ack = 1'b0; bus.fifo_full = 1'b0;
    bus2.mem_ack = 1'b1; bus2.mem_rvalid = 1'b0; bus2.mem_rdata = 32'd0; bus2.fifo_full = 1'b0;
    repeat (3) tick();

    check("rst_busy",       32'(busy),           32'd0);
    check("rst_mem_req",    32'(bus.mem_req),    32'd0);
    check("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    check("rst_fifo_valid", 32'(bus.fifo_valid), 32'd0);
    check("rst_fifo_data",  32'(bus.fifo_data),  32'd0);
    check("rst_overrun",    32'(overrun),        32'd0);

    // Full 4x2 frame, low address bits of fb_base ignored
    reset = 1'b1; tick();
    enable = 1'b1; fb_base = 26'h103; bus.mem_ack = 1'b1;
    ba = got_addr.size(); bp = got_pix.size();
    pulse_frame();
    check("ff_req",   32'(bus.mem_req),  32'd1);
    check("ff_addr0", 32'(bus.mem_addr), 32'h100);
    check("ff_busy",  32'(busy),         32'd1);
    wait_idle("ff_idle");
    check("ff_acc_cnt", 32'(got_addr.size() - ba), 32'd8);
    for (int k = 0; k < 8; k++)
      check("ff_addr", 32'(got_addr[ba+k]), 32'h100 + 32'(4*k));
    check("ff_pix_cnt", 32'(got_pix.size() - bp), 32'd8);
    for (int k = 0; k < 8; k++)
      check("ff_pix", 32'(got_pix[bp+k]), 32'((24'h100 + 24'(4*k)) ^ 24'h3C3C3C));
    check("ff_req_idle", 32'(bus.mem_req), 32'd0);

    // Stray response while idle is dropped
    auto_rsp = 1'b0; man_rd = 32'hFF123456; man_rv = 1'b1;
    tick(); man_rv = 1'b0;
    repeat (3) tick();
    check("stray_discard", 32'(got_pix.size() - bp), 32'd8);
    auto_rsp = 1'b1;

    // Stall: request and address held while not acknowledged
    bus.mem_ack = 1'b0;
    ba = got_addr.size();
    pulse_frame();
    for (int k = 0; k < 5; k++) begin
      check("stall_hold", 32'({bus.mem_req, bus.mem_addr}), 32'h0400_0100);
      tick();
    end
    bus.mem_ack = 1'b1;
    tick();
    check("stall_next_addr", 32'(bus.mem_addr), 32'h104);
    wait_idle("stall_idle");
    check("stall_acc_cnt", 32'(got_addr.size() - ba), 32'd8);

    // Backpressure mid-frame
    ba = got_addr.size(); bp = got_pix.size();
    pulse_frame();
    tick();
    bus.fifo_full = 1'b1;
    tick();
    check("bp_req_off",  32'(bus.mem_req),  32'd0);
    check("bp_addr",     32'(bus.mem_addr), 32'h108);
    repeat (5) tick();
    check("bp_req_still_off", 32'(bus.mem_req), 32'd0);
    check("bp_inflight_pix",  32'(got_pix.size() - bp), 32'd2);
    bus.fifo_full = 1'b0;
    tick();
    check("bp_resume_req",  32'(bus.mem_req),  32'd1);
    check("bp_resume_addr", 32'(bus.mem_addr), 32'h108);
    wait_idle("bp_idle");
    check("bp_acc_cnt", 32'(got_addr.size() - ba), 32'd8);
    check("bp_addr2",   32'(got_addr[ba+2]),       32'h108);

    // Enable drop: request in flight completes, then drain
    ba = got_addr.size();
    pulse_frame();
    tick(); tick();
    enable = 1'b0;
    wait_idle("en_idle");
    check("en_acc_cnt", 32'(got_addr.size() - ba), 32'd3);
    enable = 1'b1;

    // Overrun: frame_start during fetch aborts and sticks
    ba = got_addr.size();
    pulse_frame();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("ovr_flag", 32'(overrun),     32'd1);
    check("ovr_req",  32'(bus.mem_req), 32'd0);
    check("ovr_busy", 32'(busy),        32'd1);
    wait_idle("ovr_idle");
    check("ovr_acc_cnt", 32'(got_addr.size() - ba), 32'd2);
    ba = got_addr.size();
    pulse_frame();
    check("ovr_restart_addr", 32'(bus.mem_addr), 32'h100);
    check("ovr_sticky",       32'(overrun),      32'd1);
    wait_idle("ovr_restart_idle");
    check("ovr_restart_cnt", 32'(got_addr.size() - ba), 32'd8);

    // Outstanding limit on the 8x4 instance, responses withheld
    fb_base = 26'h200;
    frame_start2 = 1'b1;
    tick();
    frame_start2 = 1'b0;
    repeat (15) tick();
    check("lim_accepts", 32'(lim_acc),       32'd8);
    check("lim_req_off", 32'(bus2.mem_req),  32'd0);
    bus2.mem_rvalid = 1'b1;
    tick();
    bus2.mem_rvalid = 1'b0;
    check("lim_req_back", 32'(bus2.mem_req),  32'd1);
    check("lim_addr",     32'(bus2.mem_addr), 32'h220);
    tick();
    check("lim_accepts9", 32'(lim_acc), 32'd9);

    // Address wrap, then reset mid-frame
    fb_base = 26'h3FFFFFC;
    pulse_frame();
    check("wrap_addr0", 32'(bus.mem_addr), 32'h3FFFFFC);
    tick();
    check("wrap_addr1", 32'(bus.mem_addr), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("mid_rst_busy",       32'(busy),           32'd0);
    check("mid_rst_req",        32'(bus.mem_req),    32'd0);
    check("mid_rst_addr",       32'(bus.mem_addr),   32'd0);
    check("mid_rst_fifo_valid", 32'(bus.fifo_valid), 32'd0);
    check("mid_rst_fifo_data",  32'(bus.fifo_data),  32'd0);
    check("mid_rst_overrun",    32'(overrun),        32'd0);
    reset = 1'b1;
    bp = got_pix.size();
    repeat (5) tick();
    check("post_rst_discard", 32'(got_pix.size() - bp), 32'd0);
    check("post_rst_busy",    32'(busy),                32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_fetch_ctrl.md
VGA_FETCH_CTRL -- requirements
Module: vga_fetch_ctrl

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640, pixels per line.
REQ-002 SHALL have parameter V_LINES, default 480, lines per frame.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 8, read requests in flight; legal range 1..15.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-006 SHALL have port enable  input  1  fetch enable, level.
REQ-007 SHALL have port fb_base  input  26  framebuffer byte address; bits [1:0] ignored; sampled at frame start.
REQ-008 SHALL have port frame_start  input  1  one-cycle pulse from the pixel generator at vertical blank.
REQ-009 SHALL have port mem_req  output  1  read request valid.
REQ-010 SHALL have port mem_addr  output  26  word-aligned read byte address.
REQ-011 SHALL have port mem_ack  input  1  request accepted this cycle.
REQ-012 SHALL have port mem_rvalid  input  1  read data valid; responses return in request order.
REQ-013 SHALL have port mem_rdata  input  32  read data; pixel in [23:0].
REQ-014 SHALL have port fifo_data  output  24  pixel to the VGA FIFO.
REQ-015 SHALL have port fifo_valid  output  1  write strobe to the VGA FIFO.
REQ-016 SHALL have port fifo_full  input  1  FIFO almost-full; registered, one cycle late, asserts with fewer than 16 free slots.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port overrun  output  1  sticky: frame_start arrived before the previous frame finished.

Function
REQ-019 SHALL implement states IDLE, FETCH and DRAIN.
REQ-020 IDLE->FETCH SHALL occur on frame_start while enable=1; this SHALL load addr=fb_base&~3, x=0, y=0.
REQ-021 In FETCH, mem_req SHALL be high iff enable=1, fifo_full=0 and outstanding<MAX_OUTSTANDING.
REQ-022 mem_addr SHALL be held stable while mem_req=1 and mem_ack=0.
REQ-023 On mem_req&&mem_ack, addr SHALL advance by 4 (modulo 2^26, wrap silently) and x SHALL increment.
REQ-024 When x reaches H_PIXELS-1, x SHALL wrap to 0 and y SHALL increment; addresses SHALL be contiguous across lines.
REQ-025 Acceptance of the request for pixel (H_PIXELS-1, V_LINES-1) SHALL transition FETCH->DRAIN.
REQ-026 The outstanding counter (4 bits) SHALL increment on accept, decrement on mem_rvalid, and hold on both.
REQ-027 Every mem_rvalid, in any state, SHALL produce fifo_valid=1 with fifo_data=mem_rdata[23:0] on the next cycle (one-cycle registered latency).
REQ-028 DRAIN->IDLE SHALL occur in the cycle outstanding reaches 0.
REQ-029 enable falling in FETCH SHALL stop new requests, finish the handshake of the current request, then go to DRAIN.
REQ-030 frame_start in FETCH or DRAIN SHALL set overrun, abort (FETCH->DRAIN, no new requests), and be otherwise ignored.
REQ-031 overrun SHALL clear only on reset.
REQ-032 frame_start in IDLE with enable=0 SHALL be ignored.
REQ-033 fifo_full SHALL only gate new requests; in-flight responses SHALL always be written (the MAX_OUTSTANDING margin covers them).
REQ-034 The outstanding counter SHALL never underflow; mem_rvalid with outstanding=0 SHALL be discarded with no fifo_valid.

Reset
REQ-035 While reset=0: state=IDLE, mem_req=0, mem_addr=0, fifo_valid=0, fifo_data=0, busy=0, overrun=0, outstanding=0, x=y=0.
REQ-036 Reset mid-frame SHALL take effect in the same clock edge; responses arriving after reset releases SHALL be discarded per REQ-034.

Verification
REQ-037 Full frame: H_PIXELS=4, V_LINES=2, fb_base=0x100, mem_ack=1, 2-cycle read latency -> addresses 0x100..0x11C in order, 8 fifo_valid pulses matching the data, then IDLE with busy=0.
REQ-038 Backpressure: hold fifo_full=1 mid-frame -> mem_req=0 within 1 cycle; in-flight responses (at most MAX_OUTSTANDING) still reach the FIFO; resumes at the next address.
REQ-039 Outstanding limit: mem_ack=1, rvalid withheld -> exactly 8 accepts, then mem_req=0 until the first rvalid.
REQ-040 Stall: mem_ack=0 for 5 cycles -> mem_req and mem_addr stable throughout.
REQ-041 Overrun: frame_start during FETCH -> overrun=1, no further requests, DRAIN then IDLE; the next frame_start restarts at fb_base, and overrun stays 1.
REQ-042 Wrap/reset: fb_base=0x3FFFFFC -> second address 0x0000000; reset=0 mid-frame -> all outputs at reset values on the next cycle.
